// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared constants and types for the 7-segment scan decoder
package sseg_pkg;

    // Active-low segment patterns (bit0=a .. bit6=g) for digits 0..9
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    // All segments dark / no anode enabled
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_BLANK  = 4'b1111;

    typedef enum logic {
        ST_SETTLING = 1'b0,
        ST_HELD     = 1'b1
    } state_t;

endpackage

// File: rtl/sseg_decode.sv
// rtl/sseg_decode.sv - active-low 7-segment pattern to BCD decoder
// Ports:
//   i_seg      7-bit active-low segment pattern, bit0=a .. bit6=g
//   o_code_err high when the pattern is not one of the digits 0..9
//   o_bcd      decoded digit, 4'hF on a code error
module sseg_decode
    import sseg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic       o_code_err,
    output logic [3:0] o_bcd
);

    always_comb begin
        o_code_err = 1'b0;
        o_bcd      = 4'hF;
        case (i_seg)
            SEG_0:   o_bcd = 4'd0;
            SEG_1:   o_bcd = 4'd1;
            SEG_2:   o_bcd = 4'd2;
            SEG_3:   o_bcd = 4'd3;
            SEG_4:   o_bcd = 4'd4;
            SEG_5:   o_bcd = 4'd5;
            SEG_6:   o_bcd = 4'd6;
            SEG_7:   o_bcd = 4'd7;
            SEG_8:   o_bcd = 4'd8;
            SEG_9:   o_bcd = 4'd9;
            default: o_code_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/sseg_x4_decoder.sv
// rtl/sseg_x4_decoder.sv - rebuilds 4-digit BCD frames from multiplexed 7-segment scan lines
// Ports:
//   clk100MHz    main clock, rising edge
//   rst          asynchronous reset, active high
//   sseg_an      anode enables, active low, asynchronous
//   sseg_ca      segment lines, active low, asynchronous
//   bcd0..bcd3   last complete frame (bcd0 = digit under an[0])
//   digit_err    per-digit illegal segment code flags of the last frame
//   frame_valid  one-cycle pulse when the frame outputs update
//   anode_err    one-cycle pulse on a settled illegal anode pattern
//   stale        no successful sample for TIMEOUT cycles
module sseg_x4_decoder
    import sseg_pkg::*;
#(
    parameter int SETTLE  = 16,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic       clk100MHz,
    input  logic       rst,
    input  logic [3:0] sseg_an,
    input  logic [6:0] sseg_ca,
    output logic [3:0] bcd0,
    output logic [3:0] bcd1,
    output logic [3:0] bcd2,
    output logic [3:0] bcd3,
    output logic [3:0] digit_err,
    output logic       frame_valid,
    output logic       anode_err,
    output logic       stale
);

    localparam int            SW        = $clog2(SETTLE);
    localparam int            TW        = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(SETTLE - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);

    logic [3:0]    r_an_m, r_an_s;
    logic [6:0]    r_ca_m, r_ca_s;
    logic [10:0]   r_prev;
    logic [SW-1:0] r_stab;
    logic [TW-1:0] r_tmo;
    state_t        r_state, w_state_nx;
    logic [3:0]    r_seen;
    logic [3:0]    r_work [4];
    logic [3:0]    r_werr;
    logic [3:0]    r_bcd [4];
    logic [3:0]    r_digit_err;
    logic          r_frame_valid, r_anode_err, r_stale;

    logic          w_same, w_legal, w_blank, w_settled;
    logic          w_strobe, w_an_bad, w_tmo_hit, w_frame, w_code_err;
    logic [1:0]    w_idx;
    logic [3:0]    w_bcd;

    sseg_decode u_decode (
        .i_seg      (r_ca_s),
        .o_code_err (w_code_err),
        .o_bcd      (w_bcd)
    );

    // Two-flop synchronizer; reset to the idle (dark) pattern
    always_ff @(posedge clk100MHz or posedge rst) begin
        if (rst) begin
            r_an_m <= AN_BLANK;
            r_an_s <= AN_BLANK;
            r_ca_m <= SEG_BLANK;
            r_ca_s <= SEG_BLANK;
            r_prev <= {AN_BLANK, SEG_BLANK};
        end else begin
            r_an_m <= sseg_an;
            r_an_s <= r_an_m;
            r_ca_m <= sseg_ca;
            r_ca_s <= r_ca_m;
            r_prev <= {r_an_s, r_ca_s};
        end
    end

    assign w_same = ({r_an_s, r_ca_s} == r_prev);

    always_comb begin
        w_idx   = 2'd0;
        w_legal = 1'b0;
        w_blank = 1'b0;
        case (r_an_s)
            4'b1110:  begin w_idx = 2'd0; w_legal = 1'b1; end
            4'b1101:  begin w_idx = 2'd1; w_legal = 1'b1; end
            4'b1011:  begin w_idx = 2'd2; w_legal = 1'b1; end
            4'b0111:  begin w_idx = 2'd3; w_legal = 1'b1; end
            AN_BLANK: w_blank = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk100MHz or posedge rst) begin
        if (rst) r_state <= ST_SETTLING;
        else     r_state <= w_state_nx;
    end

    // One decision per stable pattern: settle, act once, then wait for a change
    always_comb begin
        w_state_nx = r_state;
        w_settled  = 1'b0;
        case (r_state)
            ST_SETTLING: begin
                if (w_same && r_stab == STAB_LAST) begin
                    w_settled  = 1'b1;
                    w_state_nx = ST_HELD;
                end
            end
            ST_HELD: begin
                if (!w_same) w_state_nx = ST_SETTLING;
            end
            default: w_state_nx = ST_SETTLING;
        endcase
    end

    assign w_strobe  = w_settled & w_legal;
    assign w_an_bad  = w_settled & ~w_legal & ~w_blank;
    // A sample in the expiry cycle wins: the timer restarts instead
    assign w_tmo_hit = ~w_strobe & (r_tmo == TMO_LAST);
    assign w_frame   = (r_seen == 4'b1111);

    always_ff @(posedge clk100MHz or posedge rst) begin
        if (rst) begin
            r_stab        <= '0;
            r_tmo         <= '0;
            r_seen        <= '0;
            r_werr        <= '0;
            r_digit_err   <= '0;
            r_frame_valid <= 1'b0;
            r_anode_err   <= 1'b0;
            r_stale       <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                r_work[i] <= '0;
                r_bcd[i]  <= '0;
            end
        end else begin
            if (!w_same)
                r_stab <= '0;
            else if (r_state == ST_SETTLING && !w_settled)
                r_stab <= r_stab + 1'b1;

            if (w_strobe)
                r_tmo <= '0;
            else if (r_tmo != TMO_MAX)
                r_tmo <= r_tmo + 1'b1;

            if (w_strobe) begin
                r_work[w_idx] <= w_bcd;
                r_werr[w_idx] <= w_code_err;
            end

            if (w_strobe)
                r_seen <= r_seen | (4'b0001 << w_idx);
            else if (w_an_bad || w_tmo_hit || w_frame)
                r_seen <= '0;

            r_frame_valid <= w_frame;
            r_anode_err   <= w_an_bad;
            if (w_frame) begin
                r_digit_err <= r_werr;
                for (int i = 0; i < 4; i++) r_bcd[i] <= r_work[i];
            end

            if (w_frame)
                r_stale <= 1'b0;
            else if (w_tmo_hit)
                r_stale <= 1'b1;
        end
    end

    assign bcd0        = r_bcd[0];
    assign bcd1        = r_bcd[1];
    assign bcd2        = r_bcd[2];
    assign bcd3        = r_bcd[3];
    assign digit_err   = r_digit_err;
    assign frame_valid = r_frame_valid;
    assign anode_err   = r_anode_err;
    assign stale       = r_stale;

endmodule

// File: tb/tb_sseg_x4_decoder.sv
// tb/tb_sseg_x4_decoder.sv - scoreboard bench for the 7-segment scan decoder
module tb_sseg_x4_decoder;

    localparam int SETTLE  = 16;
    localparam int TIMEOUT = 1000;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  e;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] an;
    logic [6:0] ca;
    logic [3:0] bcd0, bcd1, bcd2, bcd3, digit_err;
    logic       frame_valid, anode_err, stale;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    frame_t     exp_q [$];
    logic [3:0] m_work [4];
    logic [3:0] m_err;
    logic [3:0] m_seen;
    int         n_chk = 0, n_fail = 0;
    int         n_frames = 0, n_an_err = 0, exp_an_err = 0;

    always #5 clk = ~clk;

    sseg_x4_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk100MHz   (clk),
        .rst         (rst),
        .sseg_an     (an),
        .sseg_ca     (ca),
        .bcd0        (bcd0),
        .bcd1        (bcd1),
        .bcd2        (bcd2),
        .bcd3        (bcd3),
        .digit_err   (digit_err),
        .frame_valid (frame_valid),
        .anode_err   (anode_err),
        .stale       (stale)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] ref_decode(input logic [6:0] c);
        for (int i = 0; i < 10; i++)
            if (seg_tab[i] == c) return {1'b0, 4'(i)};
        return 5'h1F;
    endfunction

    function automatic logic [3:0] an_of(input int idx);
        logic [3:0] a;
        a = 4'b1111;
        a[idx] = 1'b0;
        return a;
    endfunction

    task automatic model_clear();
        m_seen = '0;
    endtask

    // Reference: a settled pattern is one digit write, an all-dark one nothing, anything else an anode fault
    task automatic model_apply(input logic [3:0] a, input logic [6:0] c);
        int zeros, idx;
        frame_t f;
        zeros = 0;
        idx   = 0;
        for (int i = 0; i < 4; i++)
            if (!a[i]) begin zeros++; idx = i; end
        if (zeros == 1) begin
            {m_err[idx], m_work[idx]} = ref_decode(c);
            m_seen[idx] = 1'b1;
            if (m_seen == 4'hF) begin
                f.d = {m_work[3], m_work[2], m_work[1], m_work[0]};
                f.e = m_err;
                exp_q.push_back(f);
                m_seen = '0;
            end
        end else if (zeros > 1) begin
            exp_an_err++;
            m_seen = '0;
        end
    endtask

    task automatic show(input logic [3:0] a, input logic [6:0] c, input int n);
        @(posedge clk);
        #2;
        an = a;
        ca = c;
        if (n >= SETTLE + 2) model_apply(a, c);
        repeat (n) @(posedge clk);
    endtask

    task automatic scan4(input logic [15:0] digits, input int hold, input bit glitch);
        for (int i = 0; i < 4; i++) begin
            if (glitch) show(an_of(i), seg_tab[(digits[i*4 +: 4] + 5) % 10], 10);
            show(an_of(i), seg_tab[digits[i*4 +: 4]], hold);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_valid) begin
                frame_t f;
                n_frames++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got %0h expected none at %0t",
                             {bcd3, bcd2, bcd1, bcd0}, $time);
                end else begin
                    f = exp_q.pop_front();
                    check("frame_bcd", {16'h0, bcd3, bcd2, bcd1, bcd0}, {16'h0, f.d});
                    check("frame_digit_err", {28'h0, digit_err}, {28'h0, f.e});
                    check("stale_cleared_on_frame", {31'h0, stale}, 32'h0);
                end
            end
            if (anode_err) n_an_err++;
        end
    end

    initial begin
        int fr0, ae0;
        logic [3:0] ra;
        logic [6:0] rc;
        logic [3:0] gap_an [6] = '{4'b1111, 4'b0011, 4'b0000, 4'b1010, 4'b0101, 4'b1001};

        rst = 1'b1;
        an  = 4'b1111;
        ca  = 7'h7F;
        model_clear();
        repeat (3) @(posedge clk);
        #2;
        check("reset_bcd", {16'h0, bcd3, bcd2, bcd1, bcd0}, 32'h0);
        check("reset_digit_err", {28'h0, digit_err}, 32'h0);
        check("reset_frame_valid", {31'h0, frame_valid}, 32'h0);
        check("reset_anode_err", {31'h0, anode_err}, 32'h0);
        check("reset_stale", {31'h0, stale}, 32'h1);
        rst = 1'b0;

        // Slow scan 1,2,3,4
        scan4(16'h4321, 500, 1'b0);
        check("t1_frames", n_frames, 1);
        check("t1_bcd", {16'h0, bcd3, bcd2, bcd1, bcd0}, 32'h4321);
        check("t1_stale", {31'h0, stale}, 32'h0);

        // Dark segment code on digit 2
        show(an_of(0), seg_tab[7], 40);
        show(an_of(1), seg_tab[8], 40);
        show(an_of(2), 7'h7F, 40);
        show(an_of(3), seg_tab[9], 40);
        check("t2_bcd", {16'h0, bcd3, bcd2, bcd1, bcd0}, 32'h9F87);
        check("t2_digit_err", {28'h0, digit_err}, 32'h4);

        // Short ghost patterns before each digit
        fr0 = n_frames;
        scan4(16'h0962, 30, 1'b1);
        check("t3_frames", n_frames - fr0, 1);
        check("t3_bcd", {16'h0, bcd3, bcd2, bcd1, bcd0}, 32'h0962);

        // Illegal anode mid-scan discards the partial frame
        fr0 = n_frames;
        ae0 = n_an_err;
        show(an_of(0), seg_tab[3], 40);
        show(an_of(1), seg_tab[3], 40);
        show(4'b0011, seg_tab[1], 100);
        check("t4_anode_err", n_an_err - ae0, 1);
        check("t4_no_partial_frame", n_frames - fr0, 0);
        scan4(16'h1357, 40, 1'b0);
        check("t4_frames", n_frames - fr0, 1);

        // Freeze after a frame: stale only after TIMEOUT cycles, outputs hold
        scan4(16'h8765, SETTLE + 10, 1'b0);
        repeat (800) @(posedge clk);
        #2;
        check("t5_not_yet_stale", {31'h0, stale}, 32'h0);
        repeat (400) @(posedge clk);
        #2;
        check("t5_stale", {31'h0, stale}, 32'h1);
        check("t5_bcd_hold", {16'h0, bcd3, bcd2, bcd1, bcd0}, 32'h8765);

        // Reset after two digits
        show(an_of(0), seg_tab[4], 40);
        show(an_of(1), seg_tab[4], 40);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("t6_rst_bcd", {16'h0, bcd3, bcd2, bcd1, bcd0}, 32'h0);
        check("t6_rst_stale", {31'h0, stale}, 32'h1);
        check("t6_rst_frame_valid", {31'h0, frame_valid}, 32'h0);
        an = 4'b1111;
        ca = 7'h7F;
        model_clear();
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        fr0 = n_frames;
        scan4(16'h2468, 40, 1'b0);
        check("t6_frames", n_frames - fr0, 1);

        // Random scan order, random digits, occasional bad codes, short gaps
        for (int s = 0; s < 200; s++) begin
            show(gap_an[$urandom_range(0, 5)], 7'($urandom), $urandom_range(3, 10));
            ra = an_of($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) rc = 7'($urandom);
            else                            rc = seg_tab[$urandom_range(0, 9)];
            show(ra, rc, $urandom_range(SETTLE + 4, 60));
        end

        repeat (50) @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        check("anode_err_total", n_an_err, exp_an_err);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
